signal_sel_nch: RTL and testbench

- Parametrised successor to the two-input UART-controlled signal selector: picks one of NUM_CH generator channels for the output stream.
- Decodes UART command bytes for channel select, mute and status query, and returns an ACK/NAK/status byte to the UART sender over a valid/ready handshake.
- Channel and mute changes are applied only on a sample-tick boundary, so the output stream never glitches.
- Sits between the signal generators / UART receiver and the FIR filter input / UART transmitter.

---
 rtl/signal_sel_pkg.sv | 37 +++
 rtl/uart_cmd_capture.sv | 41 ++++
 rtl/signal_sel_nch.sv | 170 +++++++++++++++++
 tb/tb_signal_sel_nch.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/signal_sel_pkg.sv
// -----------------------------------------------------------------------------
// signal_sel_pkg
// Shared definitions for the N-channel signal selector: command opcodes,
// response bytes, FSM state encoding, the pending-change record and the
// status-byte helper.
// -----------------------------------------------------------------------------
package signal_sel_pkg;

    // Command opcodes, carried in uart_data[7:6]
    localparam logic [1:0] OP_SEL  = 2'b00;
    localparam logic [1:0] OP_MUTE = 2'b01;
    localparam logic [1:0] OP_QRY  = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    // Response bytes returned to the UART sender
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    // FSM state encoding
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE   = 2'd0;
    localparam fsm_state_t ST_DECODE = 2'd1;
    localparam fsm_state_t ST_PEND   = 2'd2;
    localparam fsm_state_t ST_ACK    = 2'd3;

    // A decoded setting change waiting for the next sample tick
    typedef struct packed {
        logic       is_mute;
        logic [5:0] arg;
    } pend_t;

    // Status byte returned by QUERY: {muted, 0, channel index}
    function automatic logic [7:0] status_byte(input logic mute, input logic [5:0] sel);
        return {mute, 1'b0, sel};
    endfunction

endpackage

// File: rtl/uart_cmd_capture.sv
// -----------------------------------------------------------------------------
// uart_cmd_capture
// Rising-edge detect on the UART receive-done level plus capture of the
// received command byte.
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst    in   asynchronous active-low reset
//   uart_en    in   receive-done level; uart_data stable while high
//   uart_data  in   received byte
//   cmd_stb    out  one-cycle strobe on the first cycle uart_en is seen high
//   cmd_byte   out  byte captured on the cmd_stb cycle, valid from the next cycle
// -----------------------------------------------------------------------------
module uart_cmd_capture (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_en,
    input  logic [7:0] uart_data,
    output logic       cmd_stb,
    output logic [7:0] cmd_byte
);

    logic e1;
    logic e2;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            e1       <= 1'b0;
            e2       <= 1'b0;
            cmd_byte <= 8'h00;
        end else begin
            e1 <= uart_en;
            e2 <= e1;
            if (cmd_stb)
                cmd_byte <= uart_data;
        end
    end

    assign cmd_stb = e1 & ~e2;

endmodule

// File: rtl/signal_sel_nch.sv
// -----------------------------------------------------------------------------
// signal_sel_nch
// Selects one of NUM_CH generator channels for the output sample stream,
// controlled by UART command bytes (SELECT / MUTE / QUERY). Setting changes
// take effect only at a sample-tick boundary so the stream never glitches.
// Each accepted command is answered with ACK/NAK/status over valid/ready.
//
// Ports:
//   sys_clk, sys_rst       clock, asynchronous active-low reset
//   sig_in                 NUM_CH packed samples, channel k at [k*DATA_W +: DATA_W]
//   uart_en, uart_data     received command level and byte
//   data_out, data_out_en  registered sample and its one-cycle strobe
//   cur_sel, muted         active channel and mute status
//   ack_valid, ack_data    response byte handshake, ack_ready from the sender
//   cmd_drop               one-cycle pulse when a command arrives while busy
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a command strobe
// DECODE | classify captured byte; errors and queries answer immediately
// PEND   | valid SELECT/MUTE waiting for the next sample tick to apply
// ACK    | response presented, held until ack_ready
// -----------------------------------------------------------------------------
module signal_sel_nch
    import signal_sel_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_CH     = 4,
    parameter int SEL_W      = $clog2(NUM_CH),
    parameter int DIV        = 4,
    parameter int DEFAULT_CH = 0
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [NUM_CH*DATA_W-1:0] sig_in,
    input  logic                     uart_en,
    input  logic [7:0]               uart_data,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_out_en,
    output logic [SEL_W-1:0]         cur_sel,
    output logic                     muted,
    output logic                     ack_valid,
    output logic [7:0]               ack_data,
    input  logic                     ack_ready,
    output logic                     cmd_drop
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic             cmd_stb;
    logic [7:0]       cmd_byte;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic [DATA_W-1:0] ch_sample;
    fsm_state_t       state;
    pend_t            pend;
    logic             sel_ok;

    uart_cmd_capture u_cmd_capture (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .uart_en   (uart_en),
        .uart_data (uart_data),
        .cmd_stb   (cmd_stb),
        .cmd_byte  (cmd_byte)
    );

    // Sample-rate tick: last cycle of each DIV-cycle period
    assign tick = (tick_cnt == CNT_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    assign ch_sample = sig_in[int'(cur_sel) * DATA_W +: DATA_W];

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            data_out    <= '0;
            data_out_en <= 1'b0;
        end else begin
            data_out_en <= tick;
            if (tick)
                data_out <= muted ? '0 : ch_sample;
        end
    end

    assign sel_ok = (int'(cmd_byte[5:0]) < NUM_CH);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state     <= ST_IDLE;
            cur_sel   <= SEL_W'(DEFAULT_CH);
            muted     <= 1'b0;
            ack_valid <= 1'b0;
            ack_data  <= 8'h00;
            cmd_drop  <= 1'b0;
            pend      <= '0;
        end else begin
            // A strobe outside IDLE is discarded; the FSM does not see it
            cmd_drop <= cmd_stb && (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    if (cmd_stb)
                        state <= ST_DECODE;
                end

                ST_DECODE: begin
                    case (cmd_byte[7:6])
                        OP_SEL: begin
                            if (sel_ok) begin
                                pend  <= '{is_mute: 1'b0, arg: cmd_byte[5:0]};
                                state <= ST_PEND;
                            end else begin
                                ack_data  <= NAK_BYTE;
                                ack_valid <= 1'b1;
                                state     <= ST_ACK;
                            end
                        end
                        OP_MUTE: begin
                            pend  <= '{is_mute: 1'b1, arg: cmd_byte[5:0]};
                            state <= ST_PEND;
                        end
                        OP_QRY: begin
                            ack_data  <= status_byte(muted, 6'(cur_sel));
                            ack_valid <= 1'b1;
                            state     <= ST_ACK;
                        end
                        default: begin
                            ack_data  <= NAK_BYTE;
                            ack_valid <= 1'b1;
                            state     <= ST_ACK;
                        end
                    endcase
                end

                // The tick-cycle sample still uses the old setting because
                // data_out and the setting update share this edge.
                ST_PEND: begin
                    if (tick) begin
                        if (pend.is_mute)
                            muted <= pend.arg[0];
                        else
                            cur_sel <= pend.arg[SEL_W-1:0];
                        ack_data  <= ACK_BYTE;
                        ack_valid <= 1'b1;
                        state     <= ST_ACK;
                    end
                end

                ST_ACK: begin
                    if (ack_ready) begin
                        ack_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_signal_sel_nch.sv
module tb_signal_sel_nch;

    localparam int DATA_W = 8;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int DIV    = 4;

    logic                     sys_clk = 1'b0;
    logic                     sys_rst;
    logic [NUM_CH*DATA_W-1:0] sig_in;
    logic                     uart_en;
    logic [7:0]               uart_data;
    logic [DATA_W-1:0]        data_out;
    logic                     data_out_en;
    logic [SEL_W-1:0]         cur_sel;
    logic                     muted;
    logic                     ack_valid;
    logic [7:0]               ack_data;
    logic                     ack_ready;
    logic                     cmd_drop;

    logic [7:0] ch_val [NUM_CH];

    assign sig_in = 32'h4433_2211;

    signal_sel_nch #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .DIV(DIV), .DEFAULT_CH(0)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .sig_in      (sig_in),
        .uart_en     (uart_en),
        .uart_data   (uart_data),
        .data_out    (data_out),
        .data_out_en (data_out_en),
        .cur_sel     (cur_sel),
        .muted       (muted),
        .ack_valid   (ack_valid),
        .ack_data    (ack_data),
        .ack_ready   (ack_ready),
        .cmd_drop    (cmd_drop)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_drop_seen = 0;
    bit run = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Cycle k = number of rising edges since reset release. Ticks fall on
    // cycles with k % DIV == DIV-1, strobes one cycle after. A command whose
    // strobe is seen in cycle c is answered at c+2 (error/query), or applied
    // on the first tick at or after c+2 and answered the cycle after.
    int         cyc;
    int         apply_cyc;
    int         ack_from;
    logic [1:0] m_sel;
    logic       m_mute;
    logic [7:0] e_data;
    logic [7:0] e_ack_data;
    logic       e_drop;
    bit         outst;
    bit         has_apply;
    bit         apply_mute;
    logic [1:0] new_sel;
    logic       new_mute;
    logic [7:0] resp;
    logic       u1, u2;

    always @(negedge sys_clk) begin
        bit stb, tick, e_en, e_ackv, busy;
        logic [1:0] op;
        logic [5:0] arg;
        if (!run) begin
            cyc = 0; m_sel = 2'd0; m_mute = 1'b0; e_data = 8'h00; e_ack_data = 8'h00;
            e_drop = 1'b0; outst = 1'b0; has_apply = 1'b0; u1 = 1'b0; u2 = 1'b0;
            apply_cyc = 0; ack_from = 0; resp = 8'h00; apply_mute = 1'b0;
            new_sel = 2'd0; new_mute = 1'b0;
        end else begin
            stb    = u1 && !u2;
            tick   = (cyc % DIV) == DIV - 1;
            e_en   = (cyc >= 1) && (((cyc - 1) % DIV) == DIV - 1);
            busy   = outst;
            e_ackv = outst && (cyc >= ack_from);
            if (e_ackv) e_ack_data = resp;

            chk("data_out_en", 32'(data_out_en), 32'(e_en));
            chk("data_out",    32'(data_out),    32'(e_data));
            chk("cur_sel",     32'(cur_sel),     32'(m_sel));
            chk("muted",       32'(muted),       32'(m_mute));
            chk("ack_valid",   32'(ack_valid),   32'(e_ackv));
            chk("ack_data",    32'(ack_data),    32'(e_ack_data));
            chk("cmd_drop",    32'(cmd_drop),    32'(e_drop));
            if (cmd_drop) n_drop_seen++;

            e_drop = 1'b0;
            if (tick) e_data = m_mute ? 8'h00 : ch_val[m_sel];
            if (outst && has_apply && cyc == apply_cyc) begin
                if (apply_mute) m_mute = new_mute;
                else            m_sel  = new_sel;
            end
            if (e_ackv && ack_ready) outst = 1'b0;
            if (stb) begin
                if (busy) begin
                    e_drop = 1'b1;
                end else begin
                    op  = uart_data[7:6];
                    arg = uart_data[5:0];
                    outst = 1'b1;
                    has_apply = 1'b0;
                    if (op == 2'd0 && int'(arg) < NUM_CH) begin
                        has_apply = 1'b1; apply_mute = 1'b0; new_sel = arg[1:0];
                    end else if (op == 2'd1) begin
                        has_apply = 1'b1; apply_mute = 1'b1; new_mute = arg[0];
                    end
                    if (has_apply) begin
                        apply_cyc = cyc + 2;
                        while ((apply_cyc % DIV) != DIV - 1) apply_cyc++;
                        ack_from = apply_cyc + 1;
                        resp = 8'h06;
                    end else begin
                        ack_from = cyc + 2;
                        resp = (op == 2'd2) ? {m_mute, 1'b0, 4'b0000, m_sel} : 8'h15;
                    end
                end
            end
            u2 = u1;
            u1 = uart_en;
            cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] b, input int hold);
        step(1);
        uart_data = b;
        uart_en   = 1'b1;
        step(hold);
        uart_en   = 1'b0;
    endtask

    task automatic wait_ack(input logic [7:0] exp, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge sys_clk);
            if (ack_valid) begin
                seen = 1'b1;
                chk(name, 32'(ack_data), 32'(exp));
            end
        end
        if (!seen) timeout_fail(name);
    endtask

    task automatic wait_strobe(input logic [7:0] exp, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 2 * DIV + 2 && !seen; i++) begin
            @(negedge sys_clk);
            if (data_out_en) begin
                seen = 1'b1;
                chk(name, 32'(data_out), 32'(exp));
            end
        end
        if (!seen) timeout_fail(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        ch_val[0] = 8'h11; ch_val[1] = 8'h22; ch_val[2] = 8'h33; ch_val[3] = 8'h44;
        sys_rst = 1'b0; uart_en = 1'b0; uart_data = 8'h00; ack_ready = 1'b0;
        step(3);
        sys_rst = 1'b1;
        run = 1'b1;

        // Idle stream on default channel
        step(8);
        @(negedge sys_clk);
        chk("reset cur_sel", 32'(cur_sel), 32'h0);
        chk("reset ack_valid", 32'(ack_valid), 32'h0);
        wait_strobe(8'h11, "idle sample ch0");

        // Select channel 2
        ack_ready = 1'b1;
        send(8'h02, 3);
        wait_ack(8'h06, "select ch2 ack");
        wait_strobe(8'h33, "first ch2 sample");
        chk("cur_sel after select", 32'(cur_sel), 32'h2);

        // Errors: index out of range, reserved opcode
        send(8'h05, 3);
        wait_ack(8'h15, "out of range nak");
        chk("cur_sel after nak", 32'(cur_sel), 32'h2);
        send(8'hC0, 3);
        wait_ack(8'h15, "reserved nak");

        // Re-select active channel
        send(8'h02, 3);
        wait_ack(8'h06, "reselect ack");
        wait_strobe(8'h33, "reselect sample");

        // Mute, query, unmute
        send(8'h41, 3);
        wait_ack(8'h06, "mute ack");
        wait_strobe(8'h00, "muted sample");
        send(8'h80, 3);
        wait_ack(8'h82, "query muted ch2");
        send(8'h40, 3);
        wait_ack(8'h06, "unmute ack");
        wait_strobe(8'h33, "unmuted sample");

        // Response held off; second command dropped
        step(2);
        ack_ready = 1'b0;
        send(8'h01, 3);
        step(5);
        d0 = n_drop_seen;
        send(8'h03, 3);
        step(12);
        @(negedge sys_clk);
        chk("held ack_valid", 32'(ack_valid), 32'h1);
        chk("held ack_data", 32'(ack_data), 32'h06);
        chk("drop count", 32'(n_drop_seen - d0), 32'h1);
        chk("cur_sel first cmd only", 32'(cur_sel), 32'h1);
        step(1);
        ack_ready = 1'b1;
        step(2);
        @(negedge sys_clk);
        chk("ack released", 32'(ack_valid), 32'h0);
        step(10);
        @(negedge sys_clk);
        chk("dropped cmd no effect", 32'(cur_sel), 32'h1);

        // Reset during PEND
        send(8'h03, 3);
        sys_rst = 1'b0;
        run = 1'b0;
        #1;
        chk("rst data_out", 32'(data_out), 32'h0);
        chk("rst data_out_en", 32'(data_out_en), 32'h0);
        chk("rst cur_sel", 32'(cur_sel), 32'h0);
        chk("rst muted", 32'(muted), 32'h0);
        chk("rst ack_valid", 32'(ack_valid), 32'h0);
        chk("rst ack_data", 32'(ack_data), 32'h0);
        chk("rst cmd_drop", 32'(cmd_drop), 32'h0);
        step(3);
        sys_rst = 1'b1;
        run = 1'b1;
        wait_strobe(8'h11, "post reset sample");
        step(12);
        @(negedge sys_clk);
        chk("post reset cur_sel", 32'(cur_sel), 32'h0);
        chk("post reset no ack", 32'(ack_valid), 32'h0);

        step(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
